// File: rtl/uart8_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Line format: start bit, 8 data bits LSB first, STOP_BITS stop bits; every output is registered.
module uart8_transmitter #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       txOut
);
  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : gBadBaud
      $error("uart8_transmitter: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
      $error("uart8_transmitter: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

  stateT         state, stateNxt;
  logic [CW-1:0] baudCnt, baudNxt;
  logic [2:0]    bitIdx, bitNxt;
  logic [7:0]    shiftReg, shiftNxt, holdReg, holdNxt;
  logic          holdFull, holdFullNxt;
  logic          outNxt, busyNxt, doneNxt, readyNxt;
  logic          baudEnd, accept, frameEnd;

  assign baudEnd = (baudCnt == BAUD_LAST);
  assign accept  = txEn && txStart && txReady;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      holdReg  <= '0;
      holdFull <= 1'b0;
      txOut    <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
      txReady  <= 1'b1;
    end else begin
      state    <= stateNxt;
      baudCnt  <= baudNxt;
      bitIdx   <= bitNxt;
      shiftReg <= shiftNxt;
      holdReg  <= holdNxt;
      holdFull <= holdFullNxt;
      txOut    <= outNxt;
      txBusy   <= busyNxt;
      txDone   <= doneNxt;
      txReady  <= readyNxt;
    end
  end

  always_comb begin
    stateNxt    = state;
    baudNxt     = baudCnt;
    bitNxt      = bitIdx;
    shiftNxt    = shiftReg;
    holdNxt     = holdReg;
    holdFullNxt = holdFull;
    frameEnd    = 1'b0;
    if (state != IDLE) baudNxt = baudEnd ? '0 : baudCnt + 1'b1;
    case (state)
      START: if (baudEnd) begin
        stateNxt = DATA;
        bitNxt   = '0;
      end
      DATA: if (baudEnd) begin
        shiftNxt = {1'b0, shiftReg[7:1]};
        bitNxt   = bitIdx + 1'b1;
        if (bitIdx == 3'd7) stateNxt = STOP;
      end
      STOP: if (baudEnd) begin
        if (bitIdx == STOP_LAST) begin
          frameEnd = 1'b1;
          stateNxt = IDLE;
        end else begin
          bitNxt = bitIdx + 1'b1;
        end
      end
      default: ;
    endcase
    // A frame launches from IDLE or straight off the last stop bit; a held byte has priority.
    if (state == IDLE || frameEnd) begin
      if (holdFull && txEn) begin
        stateNxt    = START;
        baudNxt     = '0;
        bitNxt      = '0;
        shiftNxt    = holdReg;
        holdFullNxt = 1'b0;
      end else if (accept) begin
        stateNxt = START;
        baudNxt  = '0;
        bitNxt   = '0;
        shiftNxt = txIn;
      end
    end else if (accept) begin
      holdNxt     = txIn;
      holdFullNxt = 1'b1;
    end
  end

  always_comb begin
    busyNxt  = (stateNxt != IDLE);
    readyNxt = !holdFullNxt;
    doneNxt  = (stateNxt == STOP) && (baudNxt == BAUD_LAST) && (bitNxt == STOP_LAST);
    case (stateNxt)
      START:   outNxt = 1'b0;
      DATA:    outNxt = shiftNxt[0];
      default: outNxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: one-stop-bit and two-stop-bit instances share stimulus and are
// compared every cycle against a frame-position reference model, plus directed corner sequences.
module tb_uart8_transmitter;
  localparam int CPB = 10;

  logic clk = 1'b0, rstN = 1'b0, txEn = 1'b0, txStart = 1'b0;
  logic [7:0] txIn = 8'h00;
  logic [1:0] rdy, busy, done, out;

  uart8_transmitter #(.CLOCK_RATE(12000000), .BAUD_RATE(1200000), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txReady(rdy[0]), .txBusy(busy[0]), .txDone(done[0]), .txOut(out[0]));
  uart8_transmitter #(.CLOCK_RATE(12000000), .BAUD_RATE(1200000), .STOP_BITS(2)) dut1 (
    .clk(clk), .rstN(rstN), .txEn(txEn), .txStart(txStart), .txIn(txIn),
    .txReady(rdy[1]), .txBusy(busy[1]), .txDone(done[1]), .txOut(out[1]));

  always #5 clk = ~clk;

  int nChecks = 0, nFails = 0;
  bit chkOn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: a frame is a byte plus the number of cycles since launch; line level follows
  // from elapsed/CPB (0 = start, 1..8 = data LSB first, rest = stop).
  bit         mActive[2];
  int         mEl[2];
  logic [7:0] mCur[2], mHold[2];
  bit         mHoldV[2];

  task automatic mReset();
    for (int d = 0; d < 2; d++) begin
      mActive[d] = 1'b0;
      mEl[d]     = 0;
      mHoldV[d]  = 1'b0;
    end
  endtask

  task automatic mStep(input int d);
    int len;
    bit acc;
    len = (10 + d) * CPB;
    acc = txEn && txStart && !mHoldV[d];
    if (mActive[d]) begin
      mEl[d]++;
      if (mEl[d] == len) begin
        if (mHoldV[d] && txEn) begin
          mCur[d] = mHold[d]; mHoldV[d] = 1'b0; mEl[d] = 0;
        end else if (acc) begin
          mCur[d] = txIn; mEl[d] = 0;
        end else begin
          mActive[d] = 1'b0;
        end
      end else if (acc) begin
        mHold[d] = txIn; mHoldV[d] = 1'b1;
      end
    end else if (mHoldV[d] && txEn) begin
      mActive[d] = 1'b1; mCur[d] = mHold[d]; mHoldV[d] = 1'b0; mEl[d] = 0;
    end else if (acc) begin
      mActive[d] = 1'b1; mCur[d] = txIn; mEl[d] = 0;
    end
  endtask

  // {txOut, txBusy, txReady, txDone}
  function automatic logic [3:0] mExp(input int d);
    int len, pos;
    logic o;
    len = (10 + d) * CPB;
    if (!mActive[d]) return {1'b1, 1'b0, ~mHoldV[d], 1'b0};
    pos = mEl[d] / CPB;
    if (pos == 0) o = 1'b0;
    else if (pos <= 8) o = mCur[d][pos-1];
    else o = 1'b1;
    return {o, 1'b1, ~mHoldV[d], (mEl[d] == len - 1)};
  endfunction

  always @(posedge clk) if (rstN) for (int d = 0; d < 2; d++) mStep(d);
  always @(negedge rstN) mReset();

  always @(negedge clk) begin
    #2;
    if (chkOn) begin
      chk("model dut0", {out[0], busy[0], rdy[0], done[0]}, mExp(0));
      chk("model dut1", {out[1], busy[1], rdy[1], done[1]}, mExp(1));
    end
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic idle(input int n);
    txStart = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    logic       rstN;
    logic       en;
    logic       start;
    logic [7:0] in;
    logic [3:0] want;
  } vecT;

  vecT vt[5];
  logic [9:0] p35, pA5, pC3;
  int doneCnt, doneAt, bad;

  initial begin
    mReset();
    p35 = 10'b1001101010;  // 0,1,0,1,0,1,1,0,0,1 read from bit 0 up
    pA5 = 10'b1101001010;  // 0,1,0,1,0,0,1,0,1,1
    pC3 = 10'b1110000110;  // 0,1,1,0,0,0,0,1,1,1
    vt[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 4'b1010};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'h35, 4'b1010};
    vt[2] = '{1'b0, 1'b1, 1'b1, 8'hFF, 4'b1010};
    vt[3] = '{1'b1, 1'b0, 1'b1, 8'h35, 4'b1010};
    vt[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 4'b1010};
    for (int i = 0; i < 5; i++) begin
      rstN = vt[i].rstN; txEn = vt[i].en; txStart = vt[i].start; txIn = vt[i].in;
      step();
      chk("reset vec dut0", {out[0], busy[0], rdy[0], done[0]}, vt[i].want);
      chk("reset vec dut1", {out[1], busy[1], rdy[1], done[1]}, vt[i].want);
    end
    chkOn = 1'b1;

    // single frame; txIn scrambled mid-frame must not matter
    txEn = 1'b1; txStart = 1'b1; txIn = 8'h35;
    doneCnt = 0; doneAt = 0;
    for (int k = 1; k <= 101; k++) begin
      step();
      txStart = 1'b0; txIn = 8'($urandom);
      if (k % 10 == 5 && k < 100) chk("single bit", out[0], p35[k/10]);
      if (done[0]) begin doneCnt++; doneAt = k; end
    end
    chk("single done count", doneCnt, 1);
    chk("single done cycle", doneAt, 100);
    chk("single busy after", busy[0], 0);
    idle(30);

    // new byte offered exactly on the frame-end edge with the holding register empty
    txStart = 1'b1; txIn = 8'h35;
    for (int k = 1; k <= 101; k++) begin
      step();
      txStart = (k == 100); txIn = (k == 100) ? 8'h0F : 8'($urandom);
    end
    txStart = 1'b0;
    chk("gapless busy", busy[0], 1);
    chk("gapless start bit", out[0], 0);
    chk("gapless ready", rdy[0], 1);
    idle(130);

    // back-to-back with an overflow attempt while the holding register is full
    txStart = 1'b1; txIn = 8'h35;
    doneCnt = 0; bad = 0;
    for (int k = 1; k <= 201; k++) begin
      step();
      if (k % 10 == 5 && k < 200) chk("b2b bit", out[0], (k < 100) ? p35[k/10] : pA5[(k-100)/10]);
      if (k <= 200 && busy[0] !== 1'b1) bad++;
      if (rdy[0] !== ((k >= 21 && k <= 100) ? 1'b0 : 1'b1)) bad++;
      if (done[0] !== (k == 100 || k == 200)) bad++;
      if (done[0]) doneCnt++;
      txStart = (k == 20 || k == 50);
      txIn = (k == 20) ? 8'hA5 : (k == 50) ? 8'hFF : 8'($urandom);
    end
    chk("b2b window errors", bad, 0);
    chk("b2b done count", doneCnt, 2);
    chk("b2b overflow dropped", busy[0], 0);
    idle(40);

    // enable dropped mid-frame with a byte held (two stop bits)
    txStart = 1'b1; txIn = 8'h35;
    bad = 0;
    for (int k = 1; k <= 131; k++) begin
      step();
      if (k <= 130 && done[1] !== (k == 110)) bad++;
      if (k >= 111 && k <= 130 && (busy[1] !== 1'b0 || out[1] !== 1'b1)) bad++;
      if (k >= 21 && k <= 130 && rdy[1] !== 1'b0) bad++;
      txStart = (k == 20); txIn = (k == 20) ? 8'hA5 : 8'($urandom);
      if (k == 30) txEn = 1'b0;
      if (k == 130) txEn = 1'b1;
    end
    chk("gate window errors", bad, 0);
    chk("gate relaunch busy", busy[1], 1);
    chk("gate relaunch start bit", out[1], 0);
    idle(240);

    // reset in the middle of a frame
    txStart = 1'b1; txIn = 8'h35;
    for (int k = 1; k <= 35; k++) begin
      step();
      txStart = 1'b0;
    end
    #1; rstN = 1'b0; #1;
    chk("midreset dut0", {out[0], busy[0], rdy[0], done[0]}, 4'b1010);
    chk("midreset dut1", {out[1], busy[1], rdy[1], done[1]}, 4'b1010);
    bad = 0;
    repeat (3) begin step(); if (done !== 2'b00) bad++; end
    chk("midreset no done", bad, 0);
    rstN = 1'b1;
    step();
    chk("after reset busy/ready", {busy[0], rdy[0]}, 2'b01);
    txStart = 1'b1; txIn = 8'hC3;
    doneAt = 0;
    for (int k = 1; k <= 101; k++) begin
      step();
      txStart = 1'b0;
      if (k % 10 == 5 && k < 100) chk("post-reset bit", out[0], pC3[k/10]);
      if (done[0]) doneAt = k;
    end
    chk("post-reset done cycle", doneAt, 100);
    idle(30);

    // random traffic, checked cycle by cycle against the model
    for (int k = 0; k < 4000; k++) begin
      step();
      rstN    = ($urandom % 1500) != 0;
      txEn    = ($urandom % 16) != 0;
      txStart = ($urandom % 25) == 0;
      txIn    = 8'($urandom);
    end
    step();
    rstN = 1'b1; txEn = 1'b1;
    idle(250);
    chk("drained dut0", {out[0], busy[0], rdy[0]}, 3'b101);
    chk("drained dut1", {out[1], busy[1], rdy[1]}, 3'b101);

    chkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
